// File: rtl/hazard_pkg.sv
// Shared types and encodings for the EX-stage forwarding / stall controller.
package hazard_pkg;

    // Register-index width of the shadow slots; the top checks that its
    // REG_AW parameter agrees with this value.
    localparam int HZ_REG_AW = 5;

    // Operand mux select encoding.
    localparam logic [1:0] FWD_REG = 2'b00;  // register file read data
    localparam logic [1:0] FWD_WB  = 2'b01;  // MEM/WB write-back data
    localparam logic [1:0] FWD_MEM = 2'b10;  // EX/MEM ALU result

    // Shadow of the instruction currently in EX.
    typedef struct packed {
        logic                 v;
        logic [HZ_REG_AW-1:0] rs;
        logic [HZ_REG_AW-1:0] rt;
        logic                 uses_rs;
        logic                 uses_rt;
        logic [HZ_REG_AW-1:0] rd;
        logic                 regwrite;
        logic                 memread;
    } ex_slot_t;

    // Shadow of the instruction currently in MEM.
    typedef struct packed {
        logic                 v;
        logic [HZ_REG_AW-1:0] rd;
        logic                 regwrite;
        logic                 memread;
    } mem_slot_t;

    // Shadow of the instruction currently in WB.
    typedef struct packed {
        logic                 v;
        logic [HZ_REG_AW-1:0] rd;
        logic                 regwrite;
    } wb_slot_t;

endpackage

// File: rtl/fwd_select.sv
// Per-operand forwarding select: MEM result wins over WB data, r0 is never
// forwarded, and nothing is forwarded for an operand EX does not read.
module fwd_select
    import hazard_pkg::*;
#(
    parameter int AW = 5
) (
    input  logic          ex_v_i,
    input  logic          ex_uses_i,
    input  logic [AW-1:0] ex_src_i,
    input  logic          mem_v_i,
    input  logic          mem_regwrite_i,
    input  logic [AW-1:0] mem_rd_i,
    input  logic          wb_v_i,
    input  logic          wb_regwrite_i,
    input  logic [AW-1:0] wb_rd_i,
    output logic [1:0]    fwd_o
);

    logic mem_hit;
    logic wb_hit;

    // Producer match tests against the MEM and WB shadows.
    always_comb begin
        mem_hit = mem_v_i && mem_regwrite_i && (mem_rd_i != '0) && (mem_rd_i == ex_src_i);
        wb_hit  = wb_v_i && wb_regwrite_i && (wb_rd_i != '0) && (wb_rd_i == ex_src_i);
    end

    // Priority select, youngest producer first.
    always_comb begin
        fwd_o = FWD_REG;
        if (ex_v_i && ex_uses_i) begin
            if (mem_hit) begin
                fwd_o = FWD_MEM;
            end else if (wb_hit) begin
                fwd_o = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// EX-stage forwarding and pipeline stall/bubble/hold sequencer for the
// 5-stage pipeline. Tracks EX/MEM/WB register usage in shadow slots.
//
// Interface semantics: id_valid qualifies every id_* field for the current
// cycle. There is no ready signal; stall_id=1 means the ID instruction was not
// taken this cycle and must be presented again next cycle.
module hazard_fwd_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int MC_LAT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              id_multicycle,
    input  logic              flush,
    output logic [1:0]        forwarda,
    output logic [1:0]        forwardb,
    output logic              stall_id,
    output logic              bubble_ex,
    output logic              hold_ex,
    output logic              bubble_mem
);

    // Counter must be at least one bit wide even when MC_LAT == 1.
    localparam int MC_W = (MC_LAT > 1) ? $clog2(MC_LAT) : 1;

    if (REG_AW != HZ_REG_AW) begin : g_aw_check
        $error("hazard_fwd_ctrl: REG_AW must equal hazard_pkg::HZ_REG_AW");
    end

    ex_slot_t        ex_q,  ex_d;
    mem_slot_t       mem_q, mem_d;
    wb_slot_t        wb_q,  wb_d;
    logic [MC_W-1:0] mc_cnt_q, mc_cnt_d;

    logic busy;
    logic lu;

    // Busy while a multi-cycle op still owes hold cycles; load-use when ID
    // reads the destination of a load sitting in EX.
    always_comb begin
        busy = (mc_cnt_q != '0);
        lu   = id_valid && ex_q.v && ex_q.memread && (ex_q.rd != '0) &&
               ((id_uses_rs && (id_rs == ex_q.rd)) || (id_uses_rt && (id_rt == ex_q.rd)));
    end

    // Per-cycle priority: busy, then flush, then load-use, then normal advance.
    always_comb begin
        stall_id   = 1'b0;
        bubble_ex  = 1'b0;
        hold_ex    = 1'b0;
        bubble_mem = 1'b0;
        ex_d       = ex_q;
        mem_d      = '{v: ex_q.v, rd: ex_q.rd, regwrite: ex_q.regwrite, memread: ex_q.memread};
        wb_d       = '{v: mem_q.v, rd: mem_q.rd, regwrite: mem_q.regwrite};
        mc_cnt_d   = mc_cnt_q;
        if (busy) begin
            stall_id   = 1'b1;
            hold_ex    = 1'b1;
            bubble_mem = 1'b1;
            mem_d      = '0;
            mc_cnt_d   = mc_cnt_q - MC_W'(1);
        end else if (flush) begin
            bubble_ex = 1'b1;
            ex_d      = '0;
        end else if (lu) begin
            stall_id  = 1'b1;
            bubble_ex = 1'b1;
            ex_d      = '0;
        end else begin
            ex_d.v        = id_valid;
            ex_d.rs       = id_rs;
            ex_d.rt       = id_rt;
            ex_d.uses_rs  = id_uses_rs;
            ex_d.uses_rt  = id_uses_rt;
            ex_d.rd       = id_rd;
            ex_d.regwrite = id_regwrite;
            ex_d.memread  = id_memread;
            if (id_valid && id_multicycle) begin
                mc_cnt_d = MC_W'(MC_LAT - 1);
            end
        end
    end

    // Shadow slot and multi-cycle counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q     <= '0;
            mem_q    <= '0;
            wb_q     <= '0;
            mc_cnt_q <= '0;
        end else begin
            ex_q     <= ex_d;
            mem_q    <= mem_d;
            wb_q     <= wb_d;
            mc_cnt_q <= mc_cnt_d;
        end
    end

    fwd_select #(.AW(HZ_REG_AW)) u_fwd_a (
        .ex_v_i         (ex_q.v),
        .ex_uses_i      (ex_q.uses_rs),
        .ex_src_i       (ex_q.rs),
        .mem_v_i        (mem_q.v),
        .mem_regwrite_i (mem_q.regwrite),
        .mem_rd_i       (mem_q.rd),
        .wb_v_i         (wb_q.v),
        .wb_regwrite_i  (wb_q.regwrite),
        .wb_rd_i        (wb_q.rd),
        .fwd_o          (forwarda)
    );

    fwd_select #(.AW(HZ_REG_AW)) u_fwd_b (
        .ex_v_i         (ex_q.v),
        .ex_uses_i      (ex_q.uses_rt),
        .ex_src_i       (ex_q.rt),
        .mem_v_i        (mem_q.v),
        .mem_regwrite_i (mem_q.regwrite),
        .mem_rd_i       (mem_q.rd),
        .wb_v_i         (wb_q.v),
        .wb_regwrite_i  (wb_q.regwrite),
        .wb_rd_i        (wb_q.rd),
        .fwd_o          (forwardb)
    );

    // A load in MEM feeding EX cannot be forwarded (data not ready); the
    // load-use stall must make this situation impossible.
    logic load_fwd_hit;
    always_comb begin
        load_fwd_hit = ex_q.v && mem_q.v && mem_q.memread && mem_q.regwrite && (mem_q.rd != '0) &&
                       ((ex_q.uses_rs && (ex_q.rs == mem_q.rd)) ||
                        (ex_q.uses_rt && (ex_q.rt == mem_q.rd)));
    end

    a_no_load_fwd : assert property (@(posedge clk) disable iff (!rst_n) !load_fwd_hit);

endmodule
